// File: rtl/icb_grant_scheduler.sv
// Round-robin owner of the shared ICB port: one grant at a time, held until done rises or the watchdog fires.
// Latency: req sampled in cycle N -> granted in N+1; release -> next grant earliest 3 cycles after done rise.
// Backpressure: requesters wait at level req while another source owns the port; urgent only reorders idle picks.
module icb_grant_scheduler #(
  parameter int NUM_SRC        = 5,
  parameter int SEL_WIDTH      = 3,
  parameter int PRIO_SRC       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [NUM_SRC-1:0]   done,
  input  logic                 urgent,
  output logic [NUM_SRC-1:0]   granted,
  output logic [SEL_WIDTH-1:0] icb_sel,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [SEL_WIDTH-1:0] timeout_src
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] last_winner;
  logic [NUM_SRC-1:0]   done_q;
  logic [NUM_SRC-1:0]   done_rise;
  logic [CNT_W-1:0]     counter;
  logic [SEL_WIDTH-1:0] winner;
  logic [SEL_WIDTH-1:0] scan_idx;
  logic                 found;

  assign done_rise = done & ~done_q;

  // Pick the next owner: urgent source first, else first requester after the last winner.
  always_comb begin
    winner   = last_winner;
    scan_idx = '0;
    found    = 1'b0;
    if (urgent && req[PRIO_SRC]) begin
      winner = SEL_WIDTH'(PRIO_SRC);
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        scan_idx = SEL_WIDTH'((int'(last_winner) + k) % NUM_SRC);
        if (!found && req[scan_idx]) begin
          winner = scan_idx;
          found  = 1'b1;
        end
      end
    end
  end

  // Grant FSM with registered outputs; icb_sel is left alone on release so the mux stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= SEL_WIDTH'(NUM_SRC - 1);
      done_q      <= '0;
      counter     <= '0;
      granted     <= '0;
      icb_sel     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timeout_src <= '0;
    end else begin
      done_q      <= done;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            granted <= NUM_SRC'(1) << winner;
            icb_sel <= winner;
            counter <= '0;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (counter != CNT_MAX) begin
            counter <= counter + 1'b1;
          end
          if (done_rise[icb_sel]) begin
            granted     <= '0;
            last_winner <= icb_sel;
            state       <= RELEASE;
          end else if ((TIMEOUT_CYCLES != 0) && (counter == CNT_LAST)) begin
            granted     <= '0;
            last_winner <= icb_sel;
            timeout_err <= 1'b1;
            timeout_src <= icb_sel;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          granted <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icb_grant_scheduler.sv
// Directed bench for icb_grant_scheduler: stimulus pushes expected grants/timeouts into queues.
// A negedge monitor pops and compares on every new grant and every timeout pulse.
// Extra directed checks cover hold, release gap, busy timing and asynchronous reset.
module tb_icb_grant_scheduler;

  localparam int N  = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic          urgent;
  logic [N-1:0]  granted;
  logic [SW-1:0] icb_sel;
  logic          busy;
  logic          timeout_err;
  logic [SW-1:0] timeout_src;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [SW-1:0] s;
  } gexp_t;

  gexp_t         gq[$];
  logic [SW-1:0] tq[$];
  logic [N-1:0]  g_prev = '0;

  always #5 clk = ~clk;

  icb_grant_scheduler #(
    .NUM_SRC(N), .SEL_WIDTH(SW), .PRIO_SRC(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .urgent(urgent),
    .granted(granted), .icb_sel(icb_sel), .busy(busy),
    .timeout_err(timeout_err), .timeout_src(timeout_src)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic gexp_t mk(input logic [SW-1:0] s);
    gexp_t e;
    e.g = N'(1) << s;
    e.s = s;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for source s to be granted, hold it for 'hold' cycles, then pulse done[s].
  task automatic serve(input logic [SW-1:0] s, input int hold);
    int n = 0;
    @(negedge clk);
    while (!granted[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!granted[s]) begin
      chk("serve_wait", 32'(granted), 32'(N'(1) << s));
    end else begin
      repeat (hold) @(posedge clk);
      #1 done[s] = 1'b1;
      @(posedge clk);
      #1 done[s] = 1'b0;
      @(negedge clk);
      chk("release_gap", 32'(granted), 32'd0);
      chk("release_busy", 32'(busy), 32'd1);
    end
  endtask

  // Monitor: every fresh grant and every timeout pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (granted != '0 && g_prev == '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(granted), 32'd0);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          chk("grant_onehot", 32'(granted), 32'(e.g));
          chk("grant_sel", 32'(icb_sel), 32'(e.s));
        end
      end
      if (timeout_err) begin
        if (tq.size() == 0) chk("unexpected_timeout", 32'(timeout_err), 32'd0);
        else chk("timeout_src", 32'(timeout_src), 32'(tq.pop_front()));
      end
    end
    g_prev = granted;
  end

  initial begin
    #1000000;
    $display("FAIL sim_watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    int held;
    int errs;
    rst_n  = 1'b0;
    req    = '0;
    done   = '0;
    urgent = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_granted", 32'(granted), 32'd0);
    chk("rst_sel", 32'(icb_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_tsrc", 32'(timeout_src), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single pulsed request on source 2, done rises 10 cycles into the grant
    req = 5'b00100;
    gq.push_back(mk(3'd2));
    step();
    req = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t1_hold", 32'(granted), 32'b00100);
      chk("t1_sel", 32'(icb_sel), 32'd2);
      step();
    end
    done[2] = 1'b1;
    @(negedge clk);
    chk("t1_hold_last", 32'(granted), 32'b00100);
    step();
    @(negedge clk);
    chk("t1_released", 32'(granted), 32'd0);
    chk("t1_busy_release", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_sel_held", 32'(icb_sel), 32'd2);
    step();
    done = '0;

    // All sources requesting: fresh round-robin history gives 0,1,2,3,4,0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) gq.push_back(mk(SW'(k % 5)));
    for (int k = 0; k < 6; k++) serve(SW'(k % 5), 3);
    req = '0;
    repeat (3) step();

    // Urgent promotes source 4 ahead of 1 (last winner is 0)
    urgent = 1'b1;
    req    = 5'b10010;
    gq.push_back(mk(3'd4));
    gq.push_back(mk(3'd1));
    serve(3'd4, 2);
    req = 5'b00010;
    serve(3'd1, 2);
    req    = '0;
    urgent = 1'b0;
    repeat (2) step();

    // Without urgent, round-robin after winner 0 picks 1 before 4
    req = 5'b00001;
    gq.push_back(mk(3'd0));
    serve(3'd0, 2);
    req = 5'b10010;
    gq.push_back(mk(3'd1));
    gq.push_back(mk(3'd4));
    serve(3'd1, 2);
    req = 5'b10000;
    serve(3'd4, 2);
    req = '0;
    repeat (3) step();

    // Watchdog: source 3 never signals done
    req = 5'b01000;
    gq.push_back(mk(3'd3));
    tq.push_back(3'd3);
    step();
    req  = '0;
    held = 0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (granted[3]) held++;
      if (timeout_err) errs++;
      step();
    end
    chk("t4_held_cycles", 32'(held), 32'd16);
    chk("t4_err_pulses", 32'(errs), 32'd1);
    chk("t4_tsrc_held", 32'(timeout_src), 32'd3);

    // done[1] already high at grant: needs a fresh rising edge; done[4] is ignored
    done[1] = 1'b1;
    repeat (2) step();
    req = 5'b00010;
    gq.push_back(mk(3'd1));
    step();
    req = '0;
    repeat (3) step();
    done[4] = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t5_held_level", 32'(granted), 32'b00010);
    step();
    done[1] = 1'b0;
    step();
    @(negedge clk);
    chk("t5_held_low", 32'(granted), 32'b00010);
    step();
    done[1] = 1'b1;
    @(negedge clk);
    chk("t5_held_edge", 32'(granted), 32'b00010);
    step();
    @(negedge clk);
    chk("t5_released", 32'(granted), 32'd0);
    step();
    done = '0;
    repeat (3) step();

    // Asynchronous reset during a grant of source 2, then history is lost
    req = 5'b00100;
    gq.push_back(mk(3'd2));
    step();
    req = '0;
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_granted", 32'(granted), 32'd0);
    chk("t6_async_sel", 32'(icb_sel), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    req = 5'b00110;
    repeat (2) step();
    gq.push_back(mk(3'd1));
    gq.push_back(mk(3'd2));
    rst_n = 1'b1;
    serve(3'd1, 2);
    req = 5'b00100;
    serve(3'd2, 2);
    req = '0;
    repeat (4) step();

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("timeout_queue_drained", 32'(tq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icb_grant_scheduler.md
Name: icb_grant_scheduler

Overview:
Round-robin scheduler for the single shared ICB memory port used by the MMA loaders (IA, weight, bias, requant params) and the OA writer.
- Grants one requester at a time.
- Holds the grant until that requester signals completion.
- Drives the ICB mux select.
- Urgent priority for one source when the output FIFO backs up.
- Watchdog that force-releases a stuck grant.
- Sits inside the MMA control path in place of a fixed-priority arbiter.

Parameters:
NUM_SRC, 5, number of requesters (index 0..NUM_SRC-1: IA, weight, bias, requant, OA writer)
SEL_WIDTH, 3, width of icb_sel; must satisfy 2^SEL_WIDTH >= NUM_SRC
PRIO_SRC, 4, index promoted to highest priority while urgent is high
TIMEOUT_CYCLES, 1024, max cycles a grant may be held; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req  in  NUM_SRC  per-source access request, level
done  in  NUM_SRC  per-source completion (data valid / write done), level
urgent  in  1  promote PRIO_SRC (tied to FIFO-full)
granted  out  NUM_SRC  one-hot grant, registered
icb_sel  out  SEL_WIDTH  index of current/last granted source, registered
busy  out  1  high while in GRANT or RELEASE
timeout_err  out  1  single-cycle pulse on forced release
timeout_src  out  SEL_WIDTH  index of the source last force-released

Behaviour:
- Reset values (all asynchronous):
  - Outputs: granted=0, icb_sel=0, busy=0, timeout_err=0, timeout_src=0.
  - Internal: state=IDLE, last_winner=NUM_SRC-1 (source 0 wins first), done_q=0, counter=0.
- done_q registers done every cycle. done_rise[i] = done[i] & ~done_q[i].
- State IDLE:
  - If any req bit is set, choose winner W:
    - If urgent and req[PRIO_SRC], W=PRIO_SRC.
    - Otherwise W is the first set req bit scanning from last_winner+1 upward, wrapping modulo NUM_SRC.
  - On that edge: granted<=onehot(W), icb_sel<=W, counter<=0, state<=GRANT.
  - Grant latency: req sampled high in cycle N gives granted high in cycle N+1.
- State GRANT:
  - counter increments each cycle, saturating.
  - Normal release: if done_rise[icb_sel], then granted<=0, last_winner<=icb_sel, state<=RELEASE.
  - Forced release: if no done_rise and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, then:
    - granted<=0, last_winner<=icb_sel, state<=RELEASE;
    - timeout_err<=1 for one cycle, timeout_src<=icb_sel.
  - Dropping req while granted does not release the grant; only done_rise or timeout does.
  - Changes to urgent during GRANT never pre-empt the current grant.
- State RELEASE:
  - One idle bus-turnaround cycle; state<=IDLE.
  - Earliest next grant is 3 cycles after the done_rise cycle.
- icb_sel holds its last value through RELEASE/IDLE so the mux stays stable. Only granted indicates ownership.
- busy = (state != IDLE), registered.
- done already high when a grant starts: no rising edge occurs, so the grant is held until done falls and rises again, or until timeout.
- done bits of non-granted sources are ignored, apart from updating done_q.
- A req and done_rise on the same source in the same GRANT cycle: the grant is released. The still-asserted req competes again in IDLE under round-robin, so other pending sources win first.
- All sources requesting continuously: grant order 0,1,2,3,4,0,... while urgent is low.
- Unused req bits beyond NUM_SRC do not exist. A req on a source with an out-of-range index is impossible by construction.
- Reset asserted mid-grant: granted drops immediately (asynchronously) and round-robin history is lost.

Test Plan:
- req[2] pulsed high at cycle 10, done[2] rises at cycle 20 → granted=5'b00100 and icb_sel=2 during cycles 11..20; granted=0 at 21; busy low at 22.
- req=5'b11111 held, each done rises 3 cycles after its grant → grant sequence 0,1,2,3,4,0 with one RELEASE gap between grants.
- After grant to 0, req=5'b10010 with urgent=1 → source 4 granted before 1. With urgent=0, source 1 is granted first.
- TIMEOUT_CYCLES=16, grant to 3, done never rises → granted drops after 16 cycles held; timeout_err one-cycle pulse; timeout_src=3.
- done[1] already high at grant to source 1 → no release until done[1] toggles low then high. Confirm done rising on non-granted source 4 has no effect.
- rst_n low during GRANT of source 2 → granted=0 and icb_sel=0 asynchronously. After release with req=5'b00110, source 1 is granted first.
